// File: rtl/voice_allocator_if.sv
// MIDI note-event handshake between an event source and the voice allocator.
// An event transfers on a rising edge where ev_valid and ev_ready are both high.
interface voice_allocator_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [6:0] ev_key;
    logic [6:0] ev_vel;

    modport master (
        output ev_valid,
        output ev_on,
        output ev_key,
        output ev_vel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_on,
        input  ev_key,
        input  ev_vel,
        output ev_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans one voice per cycle for a held-key match and
// a free voice, then commits a retrigger, fresh allocation or LRU steal.
module voice_allocator #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               OSC_CLK,
    input  logic               iRST,
    voice_allocator_if.slave   ev,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic               steal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    state_t               state_r;
    state_t               state_s;
    logic                 ready_r;
    logic                 accept_s;

    logic                 lat_on_r;
    logic [6:0]           lat_key_r;
    logic [6:0]           lat_vel_r;

    logic [V_WIDTH-1:0]   scan_idx_r;
    logic                 match_found_r;
    logic [V_WIDTH-1:0]   match_idx_r;
    logic                 free_found_r;
    logic [V_WIDTH-1:0]   free_idx_r;
    logic                 hit_match_s;
    logic                 hit_free_s;

    logic [6:0]           key_r [VOICES];
    logic [V_WIDTH-1:0]   age_r [VOICES];

    logic [V_WIDTH-1:0]   oldest_s;
    logic [V_WIDTH-1:0]   tgt_s;
    logic [V_WIDTH-1:0]   tgt_age_s;
    logic                 stolen_s;

    assign ev.ev_ready = ready_r;
    assign accept_s    = ev.ev_valid && ready_r && (state_r == IDLE);

    // Next-state decode: one transfer, VOICES scan cycles, one commit cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_idx_r == LAST_IDX) begin
                    state_s = COMMIT;
                end else begin
                    state_s = SCAN;
                end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; ready is registered from the next state so it is glitch-free.
    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
        end
    end

    // Per-cycle scan hits; voice_free is sampled live so late changes only affect unscanned voices.
    always_comb begin
        hit_match_s = keys_on[scan_idx_r] && (key_r[scan_idx_r] == lat_key_r);
        hit_free_s  = voice_free[scan_idx_r] && !keys_on[scan_idx_r];
    end

    // Event latch and lowest-index match/free finders.
    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            lat_on_r      <= 1'b0;
            lat_key_r     <= 7'd0;
            lat_vel_r     <= 7'd0;
            scan_idx_r    <= '0;
            match_found_r <= 1'b0;
            match_idx_r   <= '0;
            free_found_r  <= 1'b0;
            free_idx_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Velocity-0 note-on is a note-off in MIDI running-status practice.
                        lat_on_r      <= ev.ev_on && (ev.ev_vel != 7'd0);
                        lat_key_r     <= ev.ev_key;
                        lat_vel_r     <= ev.ev_vel;
                        scan_idx_r    <= '0;
                        match_found_r <= 1'b0;
                        match_idx_r   <= '0;
                        free_found_r  <= 1'b0;
                        free_idx_r    <= '0;
                    end
                end
                SCAN: begin
                    if (hit_match_s && !match_found_r) begin
                        match_found_r <= 1'b1;
                        match_idx_r   <= scan_idx_r;
                    end
                    if (hit_free_s && !free_found_r) begin
                        free_found_r <= 1'b1;
                        free_idx_r   <= scan_idx_r;
                    end
                    scan_idx_r <= scan_idx_r + 1'b1;
                end
                default: begin
                    scan_idx_r <= scan_idx_r;
                end
            endcase
        end
    end

    // Locate the least-recently triggered voice (age VOICES-1).
    always_comb begin
        oldest_s = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (age_r[i] == LAST_IDX) begin
                oldest_s = V_WIDTH'(i);
            end else begin
                oldest_s = oldest_s;
            end
        end
    end

    // Target priority: retrigger a held key, else lowest free voice, else steal the oldest.
    always_comb begin
        stolen_s = 1'b0;
        if (match_found_r) begin
            tgt_s = match_idx_r;
        end else if (free_found_r) begin
            tgt_s = free_idx_r;
        end else begin
            tgt_s    = oldest_s;
            stolen_s = 1'b1;
        end
        tgt_age_s = age_r[tgt_s];
    end

    // Voice table: gates, stored keys and LRU ages (ages stay a permutation of 0..VOICES-1).
    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            keys_on <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_r[i] <= 7'd0;
                age_r[i] <= V_WIDTH'(i);
            end
        end else if (state_r == COMMIT) begin
            if (lat_on_r) begin
                keys_on[tgt_s] <= 1'b1;
                key_r[tgt_s]   <= lat_key_r;
                for (int j = 0; j < VOICES; j++) begin
                    if (V_WIDTH'(j) == tgt_s) begin
                        age_r[j] <= '0;
                    end else if (age_r[j] < tgt_age_s) begin
                        age_r[j] <= age_r[j] + 1'b1;
                    end
                end
            end else if (match_found_r) begin
                keys_on[match_idx_r] <= 1'b0;
            end
        end
    end

    // Registered event outputs; note_on and steal are single-cycle pulses.
    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            note_on     <= 1'b0;
            steal       <= 1'b0;
            cur_key_adr <= '0;
            cur_key_val <= 8'd0;
            cur_vel_on  <= 8'd0;
            cur_vel_off <= 8'd0;
        end else begin
            note_on <= 1'b0;
            steal   <= 1'b0;
            if (state_r == COMMIT) begin
                if (lat_on_r) begin
                    note_on     <= 1'b1;
                    steal       <= stolen_s;
                    cur_key_adr <= tgt_s;
                    cur_key_val <= {1'b0, lat_key_r};
                    cur_vel_on  <= {1'b0, lat_vel_r};
                end else if (match_found_r) begin
                    cur_key_adr <= match_idx_r;
                    cur_key_val <= {1'b0, lat_key_r};
                    cur_vel_off <= {1'b0, lat_vel_r};
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, multi-cycle
// corner sequences, and randomized events against a queue-based LRU model.
module tb_voice_allocator;

    localparam int VOICES = 8;

    logic       OSC_CLK;
    logic       iRST;
    logic [7:0] voice_free;
    logic [7:0] keys_on;
    logic       note_on;
    logic [2:0] cur_key_adr;
    logic [7:0] cur_key_val;
    logic [7:0] cur_vel_on;
    logic [7:0] cur_vel_off;
    logic       steal;

    voice_allocator_if evif ();

    voice_allocator #(.VOICES(8), .V_WIDTH(3)) dut (
        .OSC_CLK     (OSC_CLK),
        .iRST        (iRST),
        .ev          (evif),
        .voice_free  (voice_free),
        .keys_on     (keys_on),
        .note_on     (note_on),
        .cur_key_adr (cur_key_adr),
        .cur_key_val (cur_key_val),
        .cur_vel_on  (cur_vel_on),
        .cur_vel_off (cur_vel_off),
        .steal       (steal)
    );

    initial OSC_CLK = 1'b0;
    always #5 OSC_CLK = ~OSC_CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       on;
        logic [6:0] key;
        logic [6:0] vel;
        logic [7:0] vf;
        logic [7:0] k;
        logic       n;
        logic       s;
        logic [2:0] a;
        logic [7:0] kv;
        logic [7:0] von;
        logic [7:0] voff;
    } vec_t;

    vec_t tbl [18];

    // reference model state
    bit m_held [8];
    int m_key  [8];
    int lru_q  [$];
    int e_adr, e_kv, e_von, e_voff;
    bit e_note, e_steal;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        evif.ev_valid = 1'b0;
        repeat (2) @(posedge OSC_CLK);
        #1 iRST = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, evif.ev_ready, 1);
        check({tag, "_keys"},  keys_on, 0);
        check({tag, "_note"},  note_on, 0);
        check({tag, "_steal"}, steal, 0);
        check({tag, "_adr"},   cur_key_adr, 0);
        check({tag, "_kv"},    cur_key_val, 0);
        check({tag, "_von"},   cur_vel_on, 0);
        check({tag, "_voff"},  cur_vel_off, 0);
    endtask

    // Waits (bounded) for ready, transfers at the next rising edge, then drops valid.
    task automatic start_ev(input logic on, input logic [6:0] key, input logic [6:0] vel);
        int n = 0;
        @(negedge OSC_CLK);
        while (evif.ev_ready !== 1'b1 && n < 40) begin
            @(negedge OSC_CLK);
            n++;
        end
        check("ready_wait", evif.ev_ready, 1);
        evif.ev_valid = 1'b1;
        evif.ev_on    = on;
        evif.ev_key   = key;
        evif.ev_vel   = vel;
        @(posedge OSC_CLK);
        #1 evif.ev_valid = 1'b0;
    endtask

    // Runs the remaining scan/commit edges; optionally drives junk events the DUT must ignore.
    task automatic finish_ev(input bit scramble);
        for (int k = 1; k <= VOICES + 1; k++) begin
            if (scramble) begin
                evif.ev_valid = 1'b1;
                evif.ev_on    = 1'($urandom);
                evif.ev_key   = 7'($urandom);
                evif.ev_vel   = 7'($urandom);
            end
            @(posedge OSC_CLK);
        end
        #1 evif.ev_valid = 1'b0;
    endtask

    task automatic model_reset();
        lru_q.delete();
        for (int i = 0; i < 8; i++) begin
            m_held[i] = 1'b0;
            m_key[i]  = 0;
            lru_q.push_back(i);
        end
        e_adr = 0; e_kv = 0; e_von = 0; e_voff = 0;
        e_note = 1'b0; e_steal = 1'b0;
    endtask

    // Front of lru_q is the most recently triggered voice; the back is the steal victim.
    task automatic model_event(input bit on, input int key, input int vel, input logic [7:0] vf);
        int match, free, v;
        bit eff;
        eff = on && (vel != 0);
        match = -1;
        for (int i = 0; i < 8; i++)
            if (match < 0 && m_held[i] && m_key[i] == key) match = i;
        e_note  = 1'b0;
        e_steal = 1'b0;
        if (eff) begin
            free = -1;
            for (int i = 0; i < 8; i++)
                if (free < 0 && vf[i] && !m_held[i]) free = i;
            if (match >= 0) v = match;
            else if (free >= 0) v = free;
            else begin
                v = lru_q[lru_q.size() - 1];
                e_steal = 1'b1;
            end
            m_held[v] = 1'b1;
            m_key[v]  = key;
            e_note = 1'b1;
            e_adr = v; e_kv = key; e_von = vel;
            for (int p = 0; p < lru_q.size(); p++) begin
                if (lru_q[p] == v) begin
                    lru_q.delete(p);
                    break;
                end
            end
            lru_q.push_front(v);
        end else if (match >= 0) begin
            m_held[match] = 1'b0;
            e_adr = match; e_kv = key; e_voff = vel;
        end
    endtask

    function automatic logic [7:0] model_keys();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = m_held[i];
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer_cyc [$];
        int pulses;
        int rk, rv;
        bit ron;
        logic [7:0] rvf;

        iRST = 1'b1;
        voice_free = 8'hFF;
        evif.ev_valid = 1'b0;
        evif.ev_on = 1'b0;
        evif.ev_key = 7'd0;
        evif.ev_vel = 7'd0;

        // reset values and first-event latency
        do_reset();
        check_reset_vals("rst");
        start_ev(1'b1, 7'd60, 7'd100);
        repeat (VOICES) @(posedge OSC_CLK);
        #1;
        check("lat_early_note", note_on, 0);
        check("lat_early_ready", evif.ev_ready, 0);
        @(posedge OSC_CLK);
        #1;
        check("lat_note", note_on, 1);
        check("lat_ready", evif.ev_ready, 1);
        check("lat_adr", cur_key_adr, 0);
        check("lat_keys", keys_on, 8'h01);
        check("lat_steal", steal, 0);
        @(posedge OSC_CLK);
        #1;
        check("lat_pulse_end", note_on, 0);

        // directed vector table
        tbl[0]  = '{1'b1, 7'd60,  7'd100, 8'hFF, 8'h01, 1'b1, 1'b0, 3'd0, 8'd60,  8'd100, 8'd0};
        tbl[1]  = '{1'b1, 7'd61,  7'd101, 8'hFF, 8'h03, 1'b1, 1'b0, 3'd1, 8'd61,  8'd101, 8'd0};
        tbl[2]  = '{1'b1, 7'd62,  7'd102, 8'hFF, 8'h07, 1'b1, 1'b0, 3'd2, 8'd62,  8'd102, 8'd0};
        tbl[3]  = '{1'b1, 7'd63,  7'd103, 8'hFF, 8'h0F, 1'b1, 1'b0, 3'd3, 8'd63,  8'd103, 8'd0};
        tbl[4]  = '{1'b1, 7'd64,  7'd104, 8'hFF, 8'h1F, 1'b1, 1'b0, 3'd4, 8'd64,  8'd104, 8'd0};
        tbl[5]  = '{1'b1, 7'd65,  7'd105, 8'hFF, 8'h3F, 1'b1, 1'b0, 3'd5, 8'd65,  8'd105, 8'd0};
        tbl[6]  = '{1'b1, 7'd66,  7'd106, 8'hFF, 8'h7F, 1'b1, 1'b0, 3'd6, 8'd66,  8'd106, 8'd0};
        tbl[7]  = '{1'b1, 7'd67,  7'd107, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'd7, 8'd67,  8'd107, 8'd0};
        tbl[8]  = '{1'b1, 7'd70,  7'd90,  8'hFF, 8'hFF, 1'b1, 1'b1, 3'd0, 8'd70,  8'd90,  8'd0};
        tbl[9]  = '{1'b1, 7'd62,  7'd50,  8'hFF, 8'hFF, 1'b1, 1'b0, 3'd2, 8'd62,  8'd50,  8'd0};
        tbl[10] = '{1'b0, 7'd61,  7'd40,  8'hFF, 8'hFD, 1'b0, 1'b0, 3'd1, 8'd61,  8'd50,  8'd40};
        tbl[11] = '{1'b0, 7'd99,  7'd33,  8'hFF, 8'hFD, 1'b0, 1'b0, 3'd1, 8'd61,  8'd50,  8'd40};
        tbl[12] = '{1'b1, 7'd63,  7'd0,   8'hFF, 8'hF5, 1'b0, 1'b0, 3'd3, 8'd63,  8'd50,  8'd0};
        tbl[13] = '{1'b1, 7'd72,  7'd10,  8'hFD, 8'hFD, 1'b1, 1'b0, 3'd3, 8'd72,  8'd10,  8'd0};
        tbl[14] = '{1'b1, 7'd0,   7'd127, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'd1, 8'd0,   8'd127, 8'd0};
        tbl[15] = '{1'b0, 7'd0,   7'd1,   8'hFF, 8'hFD, 1'b0, 1'b0, 3'd1, 8'd0,   8'd127, 8'd1};
        tbl[16] = '{1'b1, 7'd127, 7'd1,   8'hFF, 8'hFF, 1'b1, 1'b0, 3'd1, 8'd127, 8'd1,   8'd1};
        tbl[17] = '{1'b0, 7'd127, 7'd127, 8'hFF, 8'hFD, 1'b0, 1'b0, 3'd1, 8'd127, 8'd1,   8'd127};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            voice_free = tbl[i].vf;
            start_ev(tbl[i].on, tbl[i].key, tbl[i].vel);
            finish_ev(1'b1);
            check($sformatf("row%0d_keys", i),  keys_on,     tbl[i].k);
            check($sformatf("row%0d_note", i),  note_on,     tbl[i].n);
            check($sformatf("row%0d_steal", i), steal,       tbl[i].s);
            check($sformatf("row%0d_adr", i),   cur_key_adr, tbl[i].a);
            check($sformatf("row%0d_kv", i),    cur_key_val, tbl[i].kv);
            check($sformatf("row%0d_von", i),   cur_vel_on,  tbl[i].von);
            check($sformatf("row%0d_voff", i),  cur_vel_off, tbl[i].voff);
        end

        // voice_free change mid-scan: voice 1 already scanned busy, voice 5 freed later
        do_reset();
        voice_free = 8'hFF;
        start_ev(1'b1, 7'd10, 7'd20);
        finish_ev(1'b0);
        voice_free = 8'h00;
        start_ev(1'b1, 7'd11, 7'd21);
        repeat (2) @(posedge OSC_CLK);
        #1 voice_free = 8'h22;
        repeat (VOICES - 1) @(posedge OSC_CLK);
        #1;
        check("midscan_adr", cur_key_adr, 5);
        check("midscan_note", note_on, 1);
        check("midscan_steal", steal, 0);
        check("midscan_keys", keys_on, 8'h21);

        // reset during scan discards the event
        voice_free = 8'hFF;
        start_ev(1'b1, 7'd20, 7'd30);
        repeat (3) @(posedge OSC_CLK);
        #1 iRST = 1'b1;
        @(posedge OSC_CLK);
        #1 iRST = 1'b0;
        check_reset_vals("midrst");
        repeat (10) @(posedge OSC_CLK);
        #1;
        check("midrst_keys_later", keys_on, 0);
        check("midrst_ready_later", evif.ev_ready, 1);

        // continuously valid source: one transfer per 10 cycles, same key retriggers one voice
        do_reset();
        @(negedge OSC_CLK);
        evif.ev_valid = 1'b1;
        evif.ev_on    = 1'b1;
        evif.ev_key   = 7'd5;
        evif.ev_vel   = 7'd5;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            if (evif.ev_ready === 1'b1) xfer_cyc.push_back(c);
            if (note_on === 1'b1) pulses++;
            @(negedge OSC_CLK);
        end
        evif.ev_valid = 1'b0;
        check("cont_xfers", xfer_cyc.size(), 5);
        for (int i = 1; i < xfer_cyc.size(); i++)
            check($sformatf("cont_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 10);
        check("cont_pulses", pulses, 4);
        repeat (12) @(posedge OSC_CLK);
        #1;
        check("cont_keys", keys_on, 8'h01);
        check("cont_adr", cur_key_adr, 0);

        // randomized events against the reference model
        do_reset();
        model_reset();
        for (int t = 0; t < 150; t++) begin
            ron = ($urandom_range(0, 2) != 0);
            rk  = $urandom_range(0, 11);
            rk  = (rk == 10) ? 0 : (rk == 11) ? 127 : 60 + rk;
            rv  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            rvf = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            voice_free = rvf;
            model_event(ron, rk, rv, rvf);
            start_ev(ron, 7'(rk), 7'(rv));
            finish_ev(1'b1);
            check($sformatf("rnd%0d_keys", t),  keys_on,     model_keys());
            check($sformatf("rnd%0d_note", t),  note_on,     e_note);
            check($sformatf("rnd%0d_steal", t), steal,       e_steal);
            check($sformatf("rnd%0d_adr", t),   cur_key_adr, e_adr);
            check($sformatf("rnd%0d_kv", t),    cur_key_val, e_kv);
            check($sformatf("rnd%0d_von", t),   cur_vel_on,  e_von);
            check($sformatf("rnd%0d_voff", t),  cur_vel_off, e_voff);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
